demux_feeder: RTL and testbench

- Sequential source stage sitting directly upstream of the 1-to-4 demultiplexer (inputs f, sel[0:1]).
- Accepts single-bit data items with a destination through a valid/ready handshake and buffers them in a small FIFO.
- Presents one item at a time on f/sel for a programmable number of cycles, then advances to the next item.
- Destination comes either from the input or from an internal round-robin pointer.

---
 rtl/demux_feeder.sv | 126 ++++++++++++
 tb/tb_demux_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/demux_feeder.sv
// Source stage for a 1-to-4 demux: buffers {data,dest} items in a small FIFO and
// presents each one on f/sel for HOLD_CYCLES cycles, back to back when more are queued.
module demux_feeder #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_data,
  input  logic [1:0]               in_dest,
  input  logic                     rr_mode,
  output logic                     f,
  output logic [0:1]               sel,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               rr_ptr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  // Entry layout: [2] = data bit, [1:0] = destination channel.
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          in_ready_reg;
  state_t        state_reg;
  logic [3:0]    hold_reg;
  logic          f_reg;
  logic [0:1]    sel_reg;
  logic          out_valid_reg;
  logic [1:0]    rr_ptr_reg;

  logic          push;
  logic          pop;
  logic [2:0]    push_entry;

  // in_ready comes from a register, so a pop in the same cycle never frees a slot early.
  assign push       = in_valid && in_ready_reg;
  assign pop        = (count_reg != '0) && ((state_reg == IDLE) || (hold_reg == 4'd0));
  assign push_entry = {in_data, (rr_mode ? rr_ptr_reg : in_dest)};

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset so it can map onto RAM; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b1;
      state_reg     <= IDLE;
      hold_reg      <= 4'd0;
      f_reg         <= 1'b0;
      sel_reg       <= 2'b00;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (rr_mode) begin
          rr_ptr_reg <= rr_ptr_reg + 2'd1;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg    <= count_next;
      in_ready_reg <= (count_next != CW'(DEPTH));

      case (state_reg)
        IDLE: begin
          if (pop) begin
            f_reg         <= mem[rd_ptr_reg][2];
            sel_reg       <= mem[rd_ptr_reg][1:0];
            out_valid_reg <= 1'b1;
            hold_reg      <= 4'(HOLD_CYCLES - 1);
            state_reg     <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_reg != 4'd0) begin
            hold_reg <= hold_reg - 4'd1;
          end else if (pop) begin
            f_reg         <= mem[rd_ptr_reg][2];
            sel_reg       <= mem[rd_ptr_reg][1:0];
            hold_reg      <= 4'(HOLD_CYCLES - 1);
          end else begin
            // sel keeps its last value while idle; only f and out_valid drop.
            f_reg         <= 1'b0;
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign f         = f_reg;
  assign sel       = sel_reg;
  assign out_valid = out_valid_reg;
  assign count     = count_reg;
  assign rr_ptr    = rr_ptr_reg;

endmodule

// File: tb/tb_demux_feeder.sv
// Drives two feeders (HOLD_CYCLES 1 and 3) with shared stimulus and compares every
// cycle against a queue-based model of item visibility.
module tb_demux_feeder;

  localparam int DEPTH = 4;
  localparam int HOLD0 = 1;
  localparam int HOLD1 = 3;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_data;
  logic [1:0] in_dest;
  logic       rr_mode;

  logic       in_ready_o  [2];
  logic       f_o         [2];
  logic [0:1] sel_o       [2];
  logic       out_valid_o [2];
  logic [2:0] count_o     [2];
  logic [1:0] rr_ptr_o    [2];

  int checks;
  int failures;

  // Model state: pending items, remaining visible cycles of the current item.
  logic [2:0] mq   [2][$];
  int         rem  [2];
  logic       mf   [2];
  logic [1:0] msel [2];
  logic [1:0] mptr [2];
  int         hold_k [2];

  demux_feeder #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode), .f(f_o[0]),
    .sel(sel_o[0]), .out_valid(out_valid_o[0]), .count(count_o[0]), .rr_ptr(rr_ptr_o[0])
  );

  demux_feeder #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode), .f(f_o[1]),
    .sel(sel_o[1]), .out_valid(out_valid_o[1]), .count(count_o[1]), .rr_ptr(rr_ptr_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_update(input int k);
    bit         push_ok;
    logic [1:0] dest;
    logic [2:0] it;
    if (reset) begin
      mq[k].delete();
      rem[k]  = 0;
      mf[k]   = 1'b0;
      msel[k] = 2'd0;
      mptr[k] = 2'd0;
    end else begin
      push_ok = in_valid && (mq[k].size() < DEPTH);
      dest    = rr_mode ? mptr[k] : in_dest;
      if (rem[k] > 1) begin
        rem[k]--;
      end else if (mq[k].size() > 0) begin
        it      = mq[k].pop_front();
        mf[k]   = it[2];
        msel[k] = it[1:0];
        rem[k]  = hold_k[k];
      end else begin
        rem[k] = 0;
        mf[k]  = 1'b0;
      end
      if (push_ok) begin
        mq[k].push_back({in_data, dest});
        if (rr_mode) mptr[k] = mptr[k] + 2'd1;
        $display("txn dut%0d push data=%0d dest=%0d occ=%0d t=%0t",
                 k, in_data, dest, mq[k].size(), $time);
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("d%0d_out_valid", k), int'(out_valid_o[k]), (rem[k] > 0) ? 1 : 0);
      check_val($sformatf("d%0d_f", k), int'(f_o[k]), int'(mf[k]));
      check_val($sformatf("d%0d_sel", k), int'(sel_o[k]), int'(msel[k]));
      check_val($sformatf("d%0d_count", k), int'(count_o[k]), mq[k].size());
      check_val($sformatf("d%0d_in_ready", k), int'(in_ready_o[k]), (mq[k].size() < DEPTH) ? 1 : 0);
      check_val($sformatf("d%0d_rr_ptr", k), int'(rr_ptr_o[k]), int'(mptr[k]));
    end
  endtask

  task automatic step(input logic v, input logic d, input logic [1:0] dst,
                      input logic rr, input logic rst);
    in_valid = v;
    in_data  = d;
    in_dest  = dst;
    rr_mode  = rr;
    reset    = rst;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    hold_k[0] = HOLD0;
    hold_k[1] = HOLD1;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; mf[k] = 1'b0; msel[k] = 2'd0; mptr[k] = 2'd0;
    end
    in_valid = 1'b0; in_data = 1'b0; in_dest = 2'd0; rr_mode = 1'b0; reset = 1'b1;

    // Reset then idle.
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(10);

    // Directed routing: (1,dest 2) then (0,dest 3).
    step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    check_val("dir_latency_not_yet", int'(out_valid_o[0]), 0);
    step(1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    check_val("dir_first_sel", int'(sel_o[0]), 2);
    idle(12);

    // Round-robin: six items, in_dest ignored.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    idle(25);
    check_val("rr_ptr_after_six", int'(rr_ptr_o[1]), 2);

    // Backpressure: in_valid held high.
    for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom), 2'($urandom), 1'b0, 1'b0);
    idle(20);

    // Hold timing: two items then nothing.
    step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    idle(10);

    // Reset mid-operation, then a fresh push.
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 2'($urandom), 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    check_val("midrst_out_valid", int'(out_valid_o[1]), 0);
    step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check_val("midrst_fresh_sel", int'(sel_o[1]), 1);
    idle(6);

    // Random traffic with varying load and occasional reset.
    for (int seg = 0; seg < 8; seg++) begin
      int pct;
      pct = 20 + 10 * seg;
      for (int i = 0; i < 60; i++) begin
        step(1'($urandom_range(99) < pct), 1'($urandom), 2'($urandom),
             1'($urandom_range(1)), 1'($urandom_range(99) < 2));
      end
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
